// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: instruction prefetch FIFO for the MIPS32 pipeline.
// Fetches words over a level req/ack handshake, queues {IR, NPC} pairs and
// hands them to decode over valid/ready. Branch redirects flush the queue.
// Optional feature macro: MIPS32_FETCHQ_HALT_STOP_EN -- when defined, pushing
// a HLT word (opcode 6'b111111) stops fetching until redirect or reset.
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  output logic [31:0]       id_ir,
  output logic [31:0]       id_npc,
  input  logic              id_ready,
  output logic [CW-1:0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       ir_mem  [DEPTH];
  logic [ADDR_W-1:0] npc_mem [DEPTH];
  logic [31:0]       last_ir_q;
  logic [ADDR_W-1:0] last_npc_q;
  logic              halted;
  logic              push, pop;
  logic              unused_rpc_hi;

  // Only the low ADDR_W bits of the branch target address instruction memory.
  assign unused_rpc_hi = ^redirect_pc[31:ADDR_W];

  assign pc_inc    = pc_q + 1'b1;
  assign imem_addr = pc_q;
  assign imem_req  = !reset && (cnt_q < CW'(DEPTH)) && !halted && !redirect;
  // imem_req already excludes the redirect cycle, so a late ack is dropped.
  assign push      = imem_req && imem_ack;
  assign pop       = id_valid && id_ready;

  assign count     = cnt_q;
  assign id_valid  = (cnt_q != '0);
  // An empty queue shows the last word handed to decode (zero after reset).
  assign id_ir     = id_valid ? ir_mem[rd_q] : last_ir_q;
  assign id_npc    = {{(32-ADDR_W){1'b0}}, (id_valid ? npc_mem[rd_q] : last_npc_q)};

  // Next-state for pc, pointers and occupancy; redirect overrides push/pop.
  always_comb begin
    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redirect) begin
      pc_d  = redirect_pc[ADDR_W-1:0];
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_inc;
        wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= ADDR_W'(RESET_PC);
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Queue storage; contents are only observed through valid entries.
  always_ff @(posedge clock) begin
    if (push) begin
      ir_mem[wr_q]  <= imem_rdata;
      npc_mem[wr_q] <= pc_inc;
    end
  end

  // Remember the most recently consumed entry for display while empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_ir_q  <= '0;
      last_npc_q <= '0;
    end else if (pop && !redirect) begin
      last_ir_q  <= ir_mem[rd_q];
      last_npc_q <= npc_mem[rd_q];
    end
  end

`ifdef MIPS32_FETCHQ_HALT_STOP_EN
  logic halted_q;
  // HLT pushed -> stop requesting; already queued entries keep draining.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                     halted_q <= 1'b0;
    else if (redirect)                             halted_q <= 1'b0;
    else if (push && imem_rdata[31:26] == 6'h3f)   halted_q <= 1'b1;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: queue-based reference model compared every
// cycle, plus directed literal expectations. Second instance covers PC wrap.
module tb_mips32_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 10;
`ifdef MIPS32_FETCHQ_HALT_STOP_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  logic          clock = 1'b0, reset = 1'b0;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          id_valid;
  logic [31:0]   id_ir, id_npc;
  logic          id_ready = 1'b0;
  logic [2:0]    count;

  // Second instance: RESET_PC at the top of memory, zero-wait, always ready.
  logic          req2, valid2, ack2 = 1'b1, ready2 = 1'b1, redir2 = 1'b0;
  logic [AW-1:0] addr2;
  logic [31:0]   rdata2, ir2, npc2, rpc2 = '0;
  logic [2:0]    count2;

  int wait_cfg = 0, wcnt = 0, hlt_addr = 2000;
  int checks = 0, passed = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .RESET_PC(0)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ir(id_ir),
    .id_npc(id_npc), .id_ready(id_ready), .count(count));

  mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .RESET_PC(1023)) dut2 (
    .clock(clock), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .redirect(redir2),
    .redirect_pc(rpc2), .id_valid(valid2), .id_ir(ir2),
    .id_npc(npc2), .id_ready(ready2), .count(count2));

  // Memory: word = 0x1000_0000 + addr, except an optional HLT location.
  function automatic logic [31:0] word_at(int a);
    return (a == hlt_addr) ? 32'hFC00_0000 : 32'h1000_0000 + 32'(a);
  endfunction

  assign imem_rdata = (int'(imem_addr) == hlt_addr) ? 32'hFC00_0000
                                                    : 32'h1000_0000 + 32'(imem_addr);
  assign rdata2     = 32'h1000_0000 + 32'(addr2);
  assign imem_ack   = (wcnt >= wait_cfg);

  // Wait-state counter: ack after wait_cfg requesting cycles.
  always @(posedge clock or posedge reset) begin
    if (reset)                      wcnt <= 0;
    else if (imem_req && imem_ack)  wcnt <= 0;
    else if (imem_req)              wcnt <= wcnt + 1;
  end

  // Reference model: an ordered list of {ir, npc} plus fetch pointer.
  logic [63:0] mq[$];
  int          m_pc = 0;
  bit          m_halted = 1'b0;
  logic [31:0] m_last_ir = '0, m_last_npc = '0;

  function automatic bit m_req();
    return !reset && (mq.size() < DEPTH) && !m_halted && !redirect;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 0; m_halted = 1'b0; m_last_ir = '0; m_last_npc = '0;
  endtask

  task automatic model_step();
    bit do_push, do_pop;
    logic [31:0] w;
    do_push = m_req() && imem_ack;
    do_pop  = (mq.size() != 0) && id_ready;
    if (redirect) begin
      mq.delete();
      m_pc = int'(redirect_pc[AW-1:0]);
      m_halted = 1'b0;
      return;
    end
    if (do_pop) {m_last_ir, m_last_npc} = mq.pop_front();
    if (do_push) begin
      w = word_at(m_pc);
      mq.push_back({w, 32'((m_pc + 1) % 1024)});
      if (HLT_EN && w[31:26] == 6'h3f) m_halted = 1'b1;
      m_pc = (m_pc + 1) % 1024;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("m.req",   32'(imem_req),  32'(m_req()));
      chk("m.addr",  32'(imem_addr), 32'(m_pc));
      chk("m.valid", 32'(id_valid),  32'(mq.size() != 0));
      chk("m.ir",    id_ir,  (mq.size() != 0) ? mq[0][63:32] : m_last_ir);
      chk("m.npc",   id_npc, (mq.size() != 0) ? mq[0][31:0]  : m_last_npc);
      chk("m.count", 32'(count),     32'(mq.size()));
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    #2 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();
    chk("rst.count", 32'(count), 0);
    chk("rst.req",   32'(imem_req), 0);
    chk("rst.addr",  32'(imem_addr), 0);
    chk("rst.valid", 32'(id_valid), 0);
    chk("rst.ir",    id_ir, 0);
    chk("rst.npc",   id_npc, 0);
    chk("rst.addr2", 32'(addr2), 1023);

    // Release: request is up in the first cycle afterwards.
    reset = 1'b0; #1;
    chk("rel.req",  32'(imem_req), 1);
    chk("rel.req2", 32'(req2), 1);

    // Streaming with zero-wait memory.
    id_ready = 1'b1;
    tick();
    chk("str.valid", 32'(id_valid), 1);
    chk("str.ir0",   id_ir, 32'h1000_0000);
    chk("str.npc0",  id_npc, 1);
    chk("wrap.addr", 32'(addr2), 0);
    chk("wrap.npc0", npc2, 0);
    tick();
    chk("str.ir1",   id_ir, 32'h1000_0001);
    chk("str.npc1",  id_npc, 2);
    chk("wrap.npc1", npc2, 1);
    chk("wrap.ir1",  ir2, 32'h1000_0000);
    chk("wrap.cnt",  32'(count2), 1);
    chk("wrap.vld",  32'(valid2), 1);
    tick();
    chk("str.ir2",   id_ir, 32'h1000_0002);
    chk("str.count", 32'(count), 1);

    // Backpressure: fill to DEPTH, then one pop reopens fetch.
    redirect = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0;
    tick();
    chk("bp.flush", 32'(count), 0);
    redirect = 1'b0;
    repeat (4) tick();
    chk("bp.full",  32'(count), 4);
    chk("bp.req0",  32'(imem_req), 0);
    chk("bp.head",  id_ir, 32'h1000_0000);
    tick();
    chk("bp.hold",  32'(count), 4);
    id_ready = 1'b1;
    tick();
    chk("bp.pop",   32'(count), 3);
    chk("bp.req1",  32'(imem_req), 1);
    chk("bp.order", id_ir, 32'h1000_0001);
    chk("bp.onpc",  id_npc, 2);
    id_ready = 1'b0;
    tick();
    chk("bp.refill", 32'(count), 4);
    id_ready = 1'b1;
    repeat (6) tick();

    // Redirect over a pending two-wait-state request at address 5.
    wait_cfg = 2; redirect = 1'b1; redirect_pc = 32'd5;
    tick();
    redirect = 1'b0; #1;
    chk("rd.addr5", 32'(imem_addr), 5);
    tick(); tick();
    chk("rd.hold5", 32'(imem_addr), 5);
    chk("rd.empty", 32'(count), 0);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("rd.addr40", 32'(imem_addr), 32'h40);
    chk("rd.cnt0",   32'(count), 0);
    chk("rd.vld0",   32'(id_valid), 0);
    redirect = 1'b0; #1;
    chk("rd.req",    32'(imem_req), 1);
    tick();
    chk("rd.npc41",  id_npc, 32'h41);
    chk("rd.ir40",   id_ir, 32'h1000_0040);
    wait_cfg = 0;
    repeat (2) tick();

    // HLT at address 3.
    hlt_addr = 3; redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    repeat (4) tick();
    chk("hlt.head", id_ir, 32'hFC00_0000);
    chk("hlt.npc",  id_npc, 4);
    chk("hlt.addr", 32'(imem_addr), 4);
`ifdef MIPS32_FETCHQ_HALT_STOP_EN
    chk("hlt.req0", 32'(imem_req), 0);
    tick();
    chk("hlt.drain", 32'(id_valid), 0);
    chk("hlt.last",  id_ir, 32'hFC00_0000);
    tick();
    chk("hlt.stay",  32'(imem_req), 0);
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0; #1;
    chk("hlt.resume", 32'(imem_req), 1);
    chk("hlt.raddr",  32'(imem_addr), 0);
`else
    chk("hlt.req1", 32'(imem_req), 1);
    tick();
    chk("hlt.next", id_ir, 32'h1000_0004);
    chk("hlt.nnpc", id_npc, 5);
`endif
    hlt_addr = 2000;

    // Asynchronous reset with three entries queued.
    redirect = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    chk("ar.pre",   32'(count), 3);
    #2 reset = 1'b1; #1;
    chk("ar.count", 32'(count), 0);
    chk("ar.valid", 32'(id_valid), 0);
    chk("ar.addr",  32'(imem_addr), 0);
    chk("ar.req",   32'(imem_req), 0);
    tick();
    reset = 1'b0; #1;
    chk("ar.req1",  32'(imem_req), 1);
    tick();
    chk("ar.ir",    id_ir, 32'h1000_0000);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
